sipo_deser_8bit: RTL

SIPO_DESER_8BIT -- requirements
Module: sipo_deser_8bit

---
 rtl/sipo_deser_8bit_pkg.sv | 16 +
 rtl/sipo_deser_8bit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sipo_deser_8bit_pkg.sv
// rtl/sipo_deser_8bit_pkg.sv - shared FSM encoding and default frame width for the serial deserialiser
//
// Purpose : constants shared by the deserialiser and anything that decodes its state.
// Ports   : none (package).

package sipo_deser_8bit_pkg;

  // Default number of data bits per frame.
  localparam int DEFAULT_DATA_W = 8;

  // FSM state encoding, 2 bits wide.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/sipo_deser_8bit.sv
// rtl/sipo_deser_8bit.sv - serial-in parallel-out frame deserialiser with parity check
//
// Purpose : collects DATA_W bits (MSB first) plus one parity bit per frame and
//           publishes good frames on data_out with a one-cycle load pulse.
// Ports   : clk         - rising-edge clock
//           async_rst   - asynchronous active-high reset
//           ser_in      - serial data bit, sampled when ser_valid=1
//           ser_valid   - qualifies ser_in and frame_start
//           frame_start - marks the current valid bit as the first bit of a frame
//           data_out    - last frame that passed the parity check
//           load        - one-cycle pulse, data_out was just updated
//           parity_err  - one-cycle pulse, parity bit did not match
//           frame_err   - one-cycle pulse, partial frame aborted by a new frame_start
//           busy        - high while a frame is in progress

module sipo_deser_8bit
  import sipo_deser_8bit_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              async_rst,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic              frame_start,
  output logic [DATA_W-1:0] data_out,
  output logic              load,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              load_q,  load_d;
  logic              perr_q,  perr_d;
  logic              ferr_q,  ferr_d;

  logic start;
  assign start = ser_valid & frame_start;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    load_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    if (start) begin
      // A frame_start always (re)opens a frame with the current bit as its MSB;
      // outside IDLE the partial frame is thrown away and flagged.
      ferr_d              = (state_q != ST_IDLE);
      state_d             = ST_SHIFT;
      shift_d             = '0;
      shift_d[DATA_W-1]   = ser_in;
      cnt_d               = CNT_ONE;
    end else if (ser_valid) begin
      case (state_q)
        ST_SHIFT: begin
          // cnt_q bits already received, so the next bit lands at DATA_W-1-cnt_q.
          for (int i = 0; i < DATA_W; i++) begin
            if (i == (DATA_W - 1 - int'(cnt_q))) begin
              shift_d[i] = ser_in;
            end
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == CNT_LAST) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (((^shift_q) ^ ser_in) == PARITY_ODD) begin
            data_d = shift_q;
            load_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        ST_IDLE: begin
          // Valid bits without frame_start carry no frame and are dropped.
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      load_q  <= load_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign load       = load_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
